// File: rtl/main_control.sv
// main_control: multicycle MIPS main controller FSM.
// Sequences fetch/decode/execute/memory/writeback.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   opcode[5:0]       IR[31:26]
//   zero              ALU zero flag
//   aluOp[2:0]        registered ALU op class
//   pcEn              PC enable (combinational)
//   irWrite regWrite memWrite  write enables
//   iorD aluSrcA aluSrcB regDst memtoReg pcSrc
//   illegalOp         DECODE pulse, bad opcode
//   state[3:0]        current state (debug)
// Option: MAIN_CONTROL_BNE_EN enables bne (op 5).
module main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [2:0] aluOp,
  output logic       pcEn,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic       iorD,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       regDst,
  output logic       memtoReg,
  output logic [1:0] pcSrc,
  output logic       illegalOp,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic       irWrite;
    logic       regWrite;
    logic       memWrite;
    logic       iorD;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       regDst;
    logic       memtoReg;
    logic [1:0] pcSrc;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
`ifdef MAIN_CONTROL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'd5;
`endif

  function automatic logic is_legal(
    input logic [5:0] op
  );
    logic ok;
    ok = (op == OP_R) || (op == OP_J) ||
         (op == OP_BEQ) || (op == OP_ADDI) ||
         (op == OP_LW) || (op == OP_SW);
`ifdef MAIN_CONTROL_BNE_EN
    ok = ok || (op == OP_BNE);
`endif
    return ok;
  endfunction

  function automatic state_e next_of(
    input state_e     s,
    input logic [5:0] op
  );
    state_e n;
    n = S_FETCH;
    case (s)
      S_FETCH: n = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW)
          n = S_MEMADR;
        else if (op == OP_R)
          n = S_RTYPEEX;
        else if (op == OP_BEQ)
          n = S_BRANCH;
        else if (op == OP_ADDI)
          n = S_ADDIEX;
        else if (op == OP_J)
          n = S_JUMP;
`ifdef MAIN_CONTROL_BNE_EN
        else if (op == OP_BNE)
          n = S_BRANCH;
`endif
      end
      S_MEMADR:
        n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   n = S_MEMWB;
      S_RTYPEEX: n = S_ALUWB;
      S_ADDIEX:  n = S_ADDIWB;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] alu_code(
    input state_e s
  );
    logic [2:0] c;
    c = 3'b000;
    if (s == S_RTYPEEX) c = 3'b010;
    if (s == S_BRANCH)  c = 3'b001;
    return c;
  endfunction

  function automatic ctrl_t ctrl_of(
    input state_e s
  );
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irWrite = 1'b1;
        c.pcWrite = 1'b1;
        c.aluSrcB = 2'b01;
      end
      S_DECODE: c.aluSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
      end
      S_MEMRD: c.iorD = 1'b1;
      S_MEMWB: begin
        c.regWrite = 1'b1;
        c.memtoReg = 1'b1;
      end
      S_MEMWR: begin
        c.iorD     = 1'b1;
        c.memWrite = 1'b1;
      end
      S_RTYPEEX: c.aluSrcA = 1'b1;
      S_BRANCH: begin
        c.aluSrcA = 1'b1;
        c.pcSrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ALUWB: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
      end
      S_ADDIWB: c.regWrite = 1'b1;
      S_JUMP: begin
        c.pcSrc   = 2'b10;
        c.pcWrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e     state_q;
  state_e     state_d;
  logic [2:0] aluOp_q;
  ctrl_t      ctrl_q;
  logic       isBne;

`ifdef MAIN_CONTROL_BNE_EN
  logic isBne_q;
  assign isBne = isBne_q;
`else
  assign isBne = 1'b0;
`endif

  assign state_d = next_of(state_q, opcode);

  // aluOp leads by one state: it names the op
  // of the state after the one being entered,
  // so the registered decoder lines up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      aluOp_q <= 3'b000;
      ctrl_q  <= ctrl_of(S_FETCH);
`ifdef MAIN_CONTROL_BNE_EN
      isBne_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      aluOp_q <= alu_code(next_of(state_d, opcode));
      ctrl_q  <= ctrl_of(state_d);
`ifdef MAIN_CONTROL_BNE_EN
      if (state_q == S_DECODE)
        isBne_q <= (opcode == OP_BNE);
`endif
    end
  end

  assign aluOp    = aluOp_q;
  assign state    = state_q;
  assign iorD     = ctrl_q.iorD;
  assign aluSrcA  = ctrl_q.aluSrcA;
  assign aluSrcB  = ctrl_q.aluSrcB;
  assign regDst   = ctrl_q.regDst;
  assign memtoReg = ctrl_q.memtoReg;
  assign pcSrc    = ctrl_q.pcSrc;

  // enables are held off for the whole reset
  assign irWrite  = rst_n & ctrl_q.irWrite;
  assign regWrite = rst_n & ctrl_q.regWrite;
  assign memWrite = rst_n & ctrl_q.memWrite;
  assign pcEn     = rst_n & (ctrl_q.pcWrite |
                    (ctrl_q.branch & (zero ^ isBne)));

  assign illegalOp = rst_n &
                     (state_q == S_DECODE) &
                     ~is_legal(opcode);

endmodule

// File: tb/tb_main_control.sv
// tb_main_control: checks main_control against
// a per-instruction state-sequence model.
module tb_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic [2:0] aluOp;
  logic       pcEn, irWrite, regWrite, memWrite;
  logic       iorD, aluSrcA, regDst, memtoReg;
  logic [1:0] aluSrcB, pcSrc;
  logic       illegalOp;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int seq [5];
  int seq_len;

  main_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .zero      (zero),
    .aluOp     (aluOp),
    .pcEn      (pcEn),
    .irWrite   (irWrite),
    .regWrite  (regWrite),
    .memWrite  (memWrite),
    .iorD      (iorD),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .regDst    (regDst),
    .memtoReg  (memtoReg),
    .pcSrc     (pcSrc),
    .illegalOp (illegalOp),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s op=%0d observed=%0h expected=%0h",
             tag, opcode, obs, exp);
    end
  endtask

  function automatic logic bne_legal();
`ifdef MAIN_CONTROL_BNE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // {ir,rw,mw,iorD,srcA,srcB,regDst,memtoReg,pcSrc}
  function automatic logic [10:0] exp_ctrl(
    input int st
  );
    case (st)
      0:    return 11'b1_0_0_0_0_01_0_0_00;
      1:    return 11'b0_0_0_0_0_11_0_0_00;
      2, 9: return 11'b0_0_0_0_1_10_0_0_00;
      3:    return 11'b0_0_0_1_0_00_0_0_00;
      4:    return 11'b0_1_0_0_0_00_0_1_00;
      5:    return 11'b0_0_1_1_0_00_0_0_00;
      6:    return 11'b0_0_0_0_1_00_0_0_00;
      7:    return 11'b0_1_0_0_0_00_1_0_00;
      8:    return 11'b0_0_0_0_1_00_0_0_01;
      10:   return 11'b0_1_0_0_0_00_0_0_00;
      11:   return 11'b0_0_0_0_0_00_0_0_10;
      default: return 11'b0;
    endcase
  endfunction

  function automatic logic [2:0] cls(input int st);
    if (st == 6) return 3'b010;
    if (st == 8) return 3'b001;
    return 3'b000;
  endfunction

  task automatic build_seq(input logic [5:0] op);
    seq[0] = 0; seq[1] = 1;
    seq[2] = 0; seq[3] = 0; seq[4] = 0;
    seq_len = 2;
    case (op)
      6'd35: begin
        seq[2] = 2; seq[3] = 3; seq[4] = 4;
        seq_len = 5;
      end
      6'd43: begin
        seq[2] = 2; seq[3] = 5; seq_len = 4;
      end
      6'd0: begin
        seq[2] = 6; seq[3] = 7; seq_len = 4;
      end
      6'd8: begin
        seq[2] = 9; seq[3] = 10; seq_len = 4;
      end
      6'd4: begin
        seq[2] = 8; seq_len = 3;
      end
      6'd5: if (bne_legal()) begin
        seq[2] = 8; seq_len = 3;
      end
      6'd2: begin
        seq[2] = 11; seq_len = 3;
      end
      default: seq_len = 2;
    endcase
  endtask

  // zmode: 0/1 fixed zero, 2 random
  task automatic run_instr(
    input logic [5:0] op,
    input int         zmode,
    input int         abort_at
  );
    logic [2:0] ea;
    logic       ep;
    logic       z;
    logic       eill;
    opcode = op;
    build_seq(op);
    for (int k = 0; k < seq_len; k++) begin
      if (zmode == 2)
        z = 1'($urandom_range(0, 1));
      else
        z = 1'(zmode);
      zero = z;
      @(negedge clk);
      ea = (k + 1 < seq_len) ? cls(seq[k+1]) : 3'd0;
      if (seq[k] == 0 || seq[k] == 11)
        ep = 1'b1;
      else if (seq[k] == 8)
        ep = (op == 6'd4) ? z : ~z;
      else
        ep = 1'b0;
      eill = (k == 1) && (seq_len == 2);
      chk("state", 16'(state), 16'(seq[k]));
      chk("aluOp", 16'(aluOp), 16'(ea));
      chk("pcEn", 16'(pcEn), 16'(ep));
      chk("illegalOp", 16'(illegalOp), 16'(eill));
      chk("ctrl",
          16'({irWrite, regWrite, memWrite, iorD,
               aluSrcA, aluSrcB, regDst, memtoReg,
               pcSrc}),
          16'(exp_ctrl(seq[k])));
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_memWrite", 16'(memWrite), 16'd0);
        chk("abort_state", 16'(state), 16'd0);
        chk("abort_en",
            16'({irWrite, regWrite, memWrite, pcEn}),
            16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] op;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_state", 16'(state), 16'd0);
      chk("rst_aluOp", 16'(aluOp), 16'd0);
      chk("rst_en",
          16'({irWrite, regWrite, memWrite, pcEn}),
          16'd0);
      chk("rst_ill", 16'(illegalOp), 16'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rel_irWrite", 16'(irWrite), 16'd1);
    chk("rel_pcEn", 16'(pcEn), 16'd1);

    run_instr(6'd35, 2, -1);
    run_instr(6'd0, 2, -1);
    run_instr(6'd4, 1, -1);
    run_instr(6'd4, 0, -1);
    run_instr(6'd5, 0, -1);
    run_instr(6'd5, 1, -1);
    run_instr(6'd63, 2, -1);
    run_instr(6'd43, 2, -1);
    run_instr(6'd8, 2, -1);
    run_instr(6'd2, 2, -1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: op = 6'd0;
        1: op = 6'd35;
        2: op = 6'd43;
        3: op = 6'd4;
        4: op = 6'd5;
        5: op = 6'd8;
        6: op = 6'd2;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, 2, -1);
    end

    run_instr(6'd43, 2, 3);
    run_instr(6'd35, 2, -1);
    run_instr(6'd0, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
